// File: rtl/adc_serial_emulator_if.sv
// adc_serial_emulator_if: controller-side pins of the dual-line serial ADC link
interface adc_serial_emulator_if;
  logic convst_in;
  logic n_cs_in;
  logic sclk_in;
  logic busy_out;
  logic data_a_out;
  logic data_b_out;
  modport master (output convst_in, n_cs_in, sclk_in, input busy_out, data_a_out, data_b_out);
  modport slave (input convst_in, n_cs_in, sclk_in, output busy_out, data_a_out, data_b_out);
endinterface

// File: rtl/adc_serial_emulator.sv
// adc_serial_emulator: ADC-side model of a 6-channel dual-line serial converter; ADC_EMU_RAMP_EN replaces chan_data_in with an internal ramp
module adc_serial_emulator #(
  parameter int W_DATA = 18,
  parameter int N_CHAN = 6,
  parameter int T_CONV = 200
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic [2:0]                 os_in,
  input  logic [W_DATA*N_CHAN-1:0]   chan_data_in,
  adc_serial_emulator_if.slave       bus,
  output logic                       frame_done_out,
  output logic                       overrun_out
);
  localparam int TX_LEN = W_DATA*N_CHAN/2;
  localparam int HALF   = N_CHAN/2;
  localparam int W_CNT  = $clog2((T_CONV << 6) + 1);
  localparam int W_BIT  = $clog2(TX_LEN + 1);
  typedef enum logic [1:0] {IDLE, CONV, WAIT_CS, SHIFT} state_t;
  state_t                    r_state;
  logic [1:0]                r_cv_s, r_cs_s, r_sk_s;
  logic                      r_cv_d, r_cs_d, r_sk_d;
  logic                      r_cv_rise, r_cs_fall, r_cs_rise, r_sk_fall;
  logic                      r_busy;
  logic [W_CNT-1:0]          r_cnt;
  logic [W_BIT-1:0]          r_bits;
  logic [W_DATA*N_CHAN-1:0]  r_snap;
  logic [TX_LEN-1:0]         r_sr_a, r_sr_b;
  logic [W_DATA*N_CHAN-1:0]  w_src;
  logic [TX_LEN-1:0]         w_line_a, w_line_b;
  logic [2:0]                w_os;
  logic [W_CNT-1:0]          w_conv_len;
  assign w_os       = (os_in == 3'd7) ? 3'd0 : os_in;
  assign w_conv_len = W_CNT'(T_CONV) << w_os;
  for (genvar i = 0; i < HALF; i++) begin : g_line
    assign w_line_a[TX_LEN-1-i*W_DATA -: W_DATA] = r_snap[i*W_DATA +: W_DATA];
    assign w_line_b[TX_LEN-1-i*W_DATA -: W_DATA] = r_snap[(i+HALF)*W_DATA +: W_DATA];
  end
`ifdef ADC_EMU_RAMP_EN
  logic [W_DATA-1:0] r_ramp;
  for (genvar k = 0; k < N_CHAN; k++) begin : g_ramp
    assign w_src[k*W_DATA +: W_DATA] = r_ramp + W_DATA'(k);
  end
  // ramp base advances once per accepted snapshot
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) r_ramp <= '0;
    else if (r_state == IDLE && r_cv_rise) r_ramp <= r_ramp + W_DATA'(1);
`else
  assign w_src = chan_data_in;
`endif
  assign bus.busy_out   = r_busy;
  assign bus.data_a_out = r_sr_a[TX_LEN-1];
  assign bus.data_b_out = r_sr_b[TX_LEN-1];
  // two-flop synchronizers, then registered single-cycle edge pulses
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      {r_cv_s, r_cs_s, r_sk_s} <= '0;
      {r_cv_d, r_cs_d, r_sk_d} <= '0;
      {r_cv_rise, r_cs_fall, r_cs_rise, r_sk_fall} <= '0;
    end else begin
      r_cv_s    <= {r_cv_s[0], bus.convst_in};
      r_cs_s    <= {r_cs_s[0], bus.n_cs_in};
      r_sk_s    <= {r_sk_s[0], bus.sclk_in};
      r_cv_d    <= r_cv_s[1];
      r_cs_d    <= r_cs_s[1];
      r_sk_d    <= r_sk_s[1];
      r_cv_rise <= r_cv_s[1] & ~r_cv_d;
      r_cs_fall <= ~r_cs_s[1] & r_cs_d;
      r_cs_rise <= r_cs_s[1] & ~r_cs_d;
      r_sk_fall <= ~r_sk_s[1] & r_sk_d;
    end
  // conversion / frame FSM; n_cs rise outranks a same-cycle sclk fall
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      r_state        <= IDLE;
      r_busy         <= 1'b0;
      r_cnt          <= '0;
      r_bits         <= '0;
      r_snap         <= '0;
      r_sr_a         <= '0;
      r_sr_b         <= '0;
      frame_done_out <= 1'b0;
      overrun_out    <= 1'b0;
    end else begin
      frame_done_out <= 1'b0;
      if (r_cv_rise && r_state != IDLE) overrun_out <= 1'b1;
      case (r_state)
        IDLE: if (r_cv_rise) begin
          r_snap  <= w_src;
          r_cnt   <= w_conv_len;
          r_busy  <= 1'b1;
          r_state <= CONV;
        end
        CONV: begin
          r_cnt <= r_cnt - W_CNT'(1);
          if (r_cnt <= W_CNT'(1)) begin
            r_busy  <= 1'b0;
            r_state <= WAIT_CS;
          end
        end
        WAIT_CS: if (r_cs_fall) begin
          r_sr_a  <= w_line_a;
          r_sr_b  <= w_line_b;
          r_bits  <= '0;
          r_state <= SHIFT;
        end
        SHIFT: if (r_cs_rise) begin
          frame_done_out <= (r_bits == W_BIT'(TX_LEN));
          r_sr_a         <= '0;
          r_sr_b         <= '0;
          r_snap         <= '0;
          r_bits         <= '0;
          r_state        <= IDLE;
        end else if (r_sk_fall && r_bits != W_BIT'(TX_LEN)) begin
          r_sr_a <= {r_sr_a[TX_LEN-2:0], 1'b0};
          r_sr_b <= {r_sr_b[TX_LEN-2:0], 1'b0};
          r_bits <= r_bits + W_BIT'(1);
        end
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_adc_serial_emulator.sv
// tb_adc_serial_emulator: directed scoreboard bench for adc_serial_emulator
module tb_adc_serial_emulator;
  localparam int W  = 18;
  localparam int N  = 6;
  localparam int TX = W*N/2;
  typedef struct {
    logic [TX-1:0] a;
    logic [TX-1:0] b;
    int            len;
  } exp_t;
  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [2:0]     os = 3'd0;
  logic [W*N-1:0] chan = '0;
  logic           frame_done;
  logic           overrun;
  logic [W-1:0]   ramp_m = '0;
  int             tests = 0;
  int             fails = 0;
  exp_t           q[$];
  adc_serial_emulator_if bus();
  adc_serial_emulator #(.W_DATA(W), .N_CHAN(N), .T_CONV(200)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .os_in(os), .chan_data_in(chan),
    .bus(bus), .frame_done_out(frame_done), .overrun_out(overrun)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [TX-1:0] obs, input logic [TX-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  function automatic logic [W*N-1:0] snap_model();
    logic [W*N-1:0] s;
`ifdef ADC_EMU_RAMP_EN
    for (int k = 0; k < N; k++) s[k*W +: W] = ramp_m + W'(k);
`else
    s = chan;
`endif
    return s;
  endfunction
  task automatic conv(input string tag, input logic [2:0] o, input int len, input bit ovr);
    exp_t e;
    logic [W*N-1:0] s;
    int n = 0;
    os = o;
    s = snap_model();
    e.a = {s[0 +: W], s[W +: W], s[2*W +: W]};
    e.b = {s[3*W +: W], s[4*W +: W], s[5*W +: W]};
    e.len = len;
    q.push_back(e);
    ramp_m = ramp_m + 1'b1;
    bus.convst_in = 1'b1;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      if (c == 3) bus.convst_in = 1'b0;
      if (ovr && n == 50) bus.convst_in = 1'b1;
      if (ovr && n == 54) bus.convst_in = 1'b0;
      if (bus.busy_out) n++;
      else if (n > 0) break;
    end
    bus.convst_in = 1'b0;
    check(tag, TX'(n), TX'(q[q.size()-1].len));
  endtask
  task automatic read_frame(input string tag, input int nbits);
    exp_t e;
    logic [TX-1:0] a = '0;
    logic [TX-1:0] b = '0;
    int done = 0;
    int extra;
    e = q.pop_front();
    extra = (nbits == TX) ? 2 : 0;
    bus.n_cs_in = 1'b0;
    tick(4);
    for (int i = 0; i < nbits + extra; i++) begin
      bus.sclk_in = 1'b1;
      if (i < nbits) begin
        a = {a[TX-2:0], bus.data_a_out};
        b = {b[TX-2:0], bus.data_b_out};
      end
      tick(4);
      bus.sclk_in = 1'b0;
      tick(4);
    end
    if (nbits == TX) begin
      check({tag, "_a"}, a, e.a);
      check({tag, "_b"}, b, e.b);
      check({tag, "_tail"}, TX'({bus.data_a_out, bus.data_b_out}), '0);
    end else begin
      check({tag, "_a_part"}, a, e.a >> (TX - nbits));
      check({tag, "_b_part"}, b, e.b >> (TX - nbits));
    end
    bus.n_cs_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (frame_done) done++;
    end
    check({tag, "_done"}, TX'(done), TX'((nbits == TX) ? 1 : 0));
  endtask
  initial begin
    int done;
    bus.convst_in = 1'b0;
    bus.n_cs_in   = 1'b1;
    bus.sclk_in   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      bus.convst_in = $urandom_range(0, 1);
      bus.n_cs_in   = $urandom_range(0, 1);
      bus.sclk_in   = $urandom_range(0, 1);
      check("reset_hold", TX'({bus.busy_out, bus.data_a_out, bus.data_b_out, frame_done, overrun}), '0);
    end
    bus.convst_in = 1'b0;
    bus.n_cs_in   = 1'b1;
    bus.sclk_in   = 1'b0;
    tick(5);
    rst_n = 1'b1;
    tick(5);
    check("post_reset", TX'({bus.busy_out, bus.data_a_out, bus.data_b_out, frame_done, overrun}), '0);
    bus.n_cs_in = 1'b0;
    tick(4);
    for (int i = 0; i < 3; i++) begin
      bus.sclk_in = 1'b1;
      tick(4);
      bus.sclk_in = 1'b0;
      tick(4);
      check("idle_cs_lines", TX'({bus.data_a_out, bus.data_b_out}), '0);
    end
    bus.n_cs_in = 1'b1;
    done = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (frame_done) done++;
    end
    check("idle_cs_done", TX'(done), '0);
    chan = {18'd6666, 18'd5555, 18'd4444, 18'd3333, 18'd2222, 18'd1111};
    conv("busy_os0", 3'd0, 200, 1'b0);
    read_frame("frame_os0", TX);
    chan = {18'h3FFFF, 18'h00001, 18'h2AAAA, 18'h15555, 18'h20000, 18'h1F0F0};
    conv("busy_os3", 3'd3, 1600, 1'b0);
    read_frame("frame_os3", TX);
    chan = {W*N{1'b0}} | {$urandom, $urandom, $urandom, $urandom};
    conv("busy_os7", 3'd7, 200, 1'b0);
    read_frame("frame_os7", TX);
    conv("busy_os6", 3'd6, 12800, 1'b0);
    read_frame("frame_os6", TX);
    conv("busy_abort", 3'd0, 200, 1'b0);
    read_frame("abort", 20);
    chan = {18'd60, 18'd50, 18'd40, 18'd30, 18'd20, 18'd10};
    conv("busy_after_abort", 3'd0, 200, 1'b0);
    read_frame("frame_after_abort", TX);
    check("no_overrun_yet", TX'(overrun), '0);
    conv("busy_overrun", 3'd0, 200, 1'b1);
    check("overrun_set", TX'(overrun), TX'(1));
    read_frame("frame_overrun", TX);
    conv("busy_after_overrun", 3'd1, 400, 1'b0);
    read_frame("frame_after_overrun", TX);
    check("overrun_sticky", TX'(overrun), TX'(1));
    bus.convst_in = 1'b1;
    tick(4);
    bus.convst_in = 1'b0;
    tick(20);
    check("midreset_busy_pre", TX'(bus.busy_out), TX'(1));
    #2 rst_n = 1'b0;
    #1 check("midreset_outs", TX'({bus.busy_out, bus.data_a_out, bus.data_b_out, frame_done, overrun}), '0);
    ramp_m = '0;
    tick(3);
    rst_n = 1'b1;
    tick(5);
    conv("busy_after_reset", 3'd0, 200, 1'b0);
    read_frame("frame_after_reset", TX);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
